// File: rtl/mmio_csr_avmm_bridge_if.sv
// MMIO request/response and Avalon-MM master signal bundle for the AFU CSR bridge.
// The slave modport is the bridge's view; the master modport is the host plus AVMM slave side.
interface mmio_csr_avmm_bridge_if #(
    parameter int AVMM_ADDR_W = 32
) ();
    // MMIO request (CCI-P c0 fields)
    logic                   mmio_wr_valid;
    logic                   mmio_rd_valid;
    logic [15:0]            mmio_addr;
    logic [8:0]             mmio_tid;
    logic [63:0]            mmio_wrdata;
    // MMIO read response (CCI-P c2 fields)
    logic                   rsp_valid;
    logic [8:0]             rsp_tid;
    logic [63:0]            rsp_data;
    // Avalon-MM master
    logic [AVMM_ADDR_W-1:0] avs_address;
    logic                   avs_write;
    logic                   avs_read;
    logic [63:0]            avs_writedata;
    logic [7:0]             avs_byteenable;
    logic                   avs_waitrequest;
    logic [63:0]            avs_readdata;
    logic                   avs_readdatavalid;

    modport slave (
        input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wrdata,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid,
        output rsp_valid, rsp_tid, rsp_data,
        output avs_address, avs_write, avs_read, avs_writedata, avs_byteenable
    );

    modport master (
        output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wrdata,
        output avs_waitrequest, avs_readdata, avs_readdatavalid,
        input  rsp_valid, rsp_tid, rsp_data,
        input  avs_address, avs_write, avs_read, avs_writedata, avs_byteenable
    );
endinterface

// File: rtl/mmio_csr_avmm_bridge.sv
// AFU CSR responder (DFH, AFU_ID, STATUS, PAGE, scratch) with a one-at-a-time
// MMIO-to-Avalon-MM window. Window accesses are aborted after TIMEOUT_CYCLES.
module mmio_csr_avmm_bridge #(
    parameter logic [63:0] AFU_ID_H       = 64'h0,
    parameter logic [63:0] AFU_ID_L       = 64'h0,
    parameter int          NUM_SCRATCH    = 4,
    parameter logic [15:0] AVMM_BASE      = 16'h1000,
    parameter int          AVMM_ADDR_W    = 32,
    parameter int          TIMEOUT_CYCLES = 512
) (
    input  logic                      Clk_400,
    input  logic                      SoftReset_n,
    mmio_csr_avmm_bridge_if.slave     bus
);
    localparam int          PAGE_W      = AVMM_ADDR_W - 14;
    localparam int          CNT_W       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [63:0] DFH_VALUE   = {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0};
    localparam logic [15:0] ADDR_DFH    = 16'h0000;
    localparam logic [15:0] ADDR_ID_L   = 16'h0002;
    localparam logic [15:0] ADDR_ID_H   = 16'h0004;
    localparam logic [15:0] ADDR_STATUS = 16'h0010;
    localparam logic [15:0] ADDR_PAGE   = 16'h0012;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_WAIT,
        ST_RSP
    } state_t;

    state_t                   state_reg, state_next;
    logic [CNT_W-1:0]         cnt_reg, cnt_next;
    logic                     avs_read_reg, avs_read_next;
    logic                     avs_write_reg, avs_write_next;
    logic [AVMM_ADDR_W-1:0]   avs_addr_reg, avs_addr_next;
    logic [63:0]              avs_wdata_reg, avs_wdata_next;
    logic [8:0]               rd_tid_reg, rd_tid_next;
    logic [63:0]              rd_data_reg, rd_data_next;
    logic                     rsp_valid_reg, rsp_valid_next;
    logic [8:0]               rsp_tid_reg, rsp_tid_next;
    logic [63:0]              rsp_data_reg, rsp_data_next;
    logic                     timeout_reg, timeout_next;
    logic [7:0]               drop_cnt_reg, drop_cnt_next;
    logic [PAGE_W-1:0]        page_reg, page_next;

    logic                     win_hit, busy;
    logic                     win_wr, win_rd, loc_wr, loc_rd;
    logic                     drop_wr, drop_rd, local_rsp, timeout_hit;
    logic [63:0]              loc_rdata;
    logic [63:0]              status_word;

    logic [NUM_SCRATCH-1:0]        scratch_hit;
    logic [NUM_SCRATCH-1:0][63:0]  scratch_q;

    assign win_hit     = (bus.mmio_addr[15:12] == AVMM_BASE[15:12]);
    assign busy        = (state_reg != ST_IDLE);
    assign win_wr      = bus.mmio_wr_valid && win_hit;
    assign win_rd      = bus.mmio_rd_valid && win_hit;
    assign loc_wr      = bus.mmio_wr_valid && !win_hit;
    assign loc_rd      = bus.mmio_rd_valid && !win_hit;
    assign drop_wr     = win_wr && busy;
    assign drop_rd     = win_rd && busy;
    // Busy-window reads are answered on the local path with all-ones.
    assign local_rsp   = loc_rd || drop_rd;
    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    assign status_word = {48'b0, drop_cnt_reg, 6'b0, timeout_reg, busy};

    // Scratch registers, one per generate slot, each decoding its own dword address
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scratch
            localparam logic [15:0] SCRATCH_ADDR = 16'(32'h0020 + 2 * gi);
            logic [63:0] value_reg;

            assign scratch_hit[gi] = (bus.mmio_addr == SCRATCH_ADDR);
            assign scratch_q[gi]   = value_reg;

            // Scratch write on a local write that hits this slot
            always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
                if (!SoftReset_n) begin
                    value_reg <= '0;
                end else if (loc_wr && scratch_hit[gi]) begin
                    value_reg <= bus.mmio_wrdata;
                end
            end
        end
    endgenerate

    // Local CSR read decode; unmapped and reserved addresses read as zero
    always_comb begin
        loc_rdata = '0;
        case (bus.mmio_addr)
            ADDR_DFH:    loc_rdata = DFH_VALUE;
            ADDR_ID_L:   loc_rdata = AFU_ID_L;
            ADDR_ID_H:   loc_rdata = AFU_ID_H;
            ADDR_STATUS: loc_rdata = status_word;
            ADDR_PAGE:   loc_rdata = 64'(page_reg);
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (scratch_hit[i]) begin
                        loc_rdata = scratch_q[i];
                    end
                end
            end
        endcase
    end

    // Bridge FSM next state, CSR side effects and response arbitration
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        avs_read_next  = avs_read_reg;
        avs_write_next = avs_write_reg;
        avs_addr_next  = avs_addr_reg;
        avs_wdata_next = avs_wdata_reg;
        rd_tid_next    = rd_tid_reg;
        rd_data_next   = rd_data_reg;
        rsp_valid_next = 1'b0;
        rsp_tid_next   = rsp_tid_reg;
        rsp_data_next  = rsp_data_reg;
        timeout_next   = timeout_reg;
        drop_cnt_next  = drop_cnt_reg;
        page_next      = page_reg;

        if (loc_wr && bus.mmio_addr == ADDR_STATUS && bus.mmio_wrdata[1]) begin
            timeout_next = 1'b0;
        end
        if (loc_wr && bus.mmio_addr == ADDR_PAGE) begin
            page_next = bus.mmio_wrdata[PAGE_W-1:0];
        end
        if ((drop_wr || drop_rd) && drop_cnt_reg != 8'hFF) begin
            drop_cnt_next = drop_cnt_reg + 8'd1;
        end

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (win_wr) begin
                    state_next     = ST_WR;
                    avs_write_next = 1'b1;
                    avs_addr_next  = {page_reg, bus.mmio_addr[11:1], 3'b000};
                    avs_wdata_next = bus.mmio_wrdata;
                end else if (win_rd) begin
                    state_next    = ST_RD;
                    avs_read_next = 1'b1;
                    avs_addr_next = {page_reg, bus.mmio_addr[11:1], 3'b000};
                    rd_tid_next   = bus.mmio_tid;
                end
            end
            ST_WR: begin
                cnt_next = cnt_reg + 1'b1;
                if (!bus.avs_waitrequest) begin
                    avs_write_next = 1'b0;
                    state_next     = ST_IDLE;
                end else if (timeout_hit) begin
                    avs_write_next = 1'b0;
                    timeout_next   = 1'b1;
                    state_next     = ST_IDLE;
                end
            end
            ST_RD: begin
                cnt_next = cnt_reg + 1'b1;
                if (!bus.avs_waitrequest) begin
                    avs_read_next = 1'b0;
                    // Zero-latency slaves may return data in the accept cycle
                    if (bus.avs_readdatavalid) begin
                        rd_data_next = bus.avs_readdata;
                        state_next   = ST_RSP;
                    end else begin
                        state_next   = ST_RD_WAIT;
                    end
                end else if (timeout_hit) begin
                    avs_read_next = 1'b0;
                    timeout_next  = 1'b1;
                    rd_data_next  = '1;
                    state_next    = ST_RSP;
                end
            end
            ST_RD_WAIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (bus.avs_readdatavalid) begin
                    rd_data_next = bus.avs_readdata;
                    state_next   = ST_RSP;
                end else if (timeout_hit) begin
                    timeout_next = 1'b1;
                    rd_data_next = '1;
                    state_next   = ST_RSP;
                end
            end
            ST_RSP: begin
                // A local response this cycle owns the response port; retry next cycle
                if (!local_rsp) begin
                    rsp_valid_next = 1'b1;
                    rsp_tid_next   = rd_tid_reg;
                    rsp_data_next  = rd_data_reg;
                    state_next     = ST_IDLE;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                avs_read_next  = 1'b0;
                avs_write_next = 1'b0;
            end
        endcase

        if (local_rsp) begin
            rsp_valid_next = 1'b1;
            rsp_tid_next   = bus.mmio_tid;
            rsp_data_next  = win_hit ? '1 : loc_rdata;
        end
    end

    // State and output registers; reset drops AVMM strobes and any pending response
    always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            avs_read_reg  <= 1'b0;
            avs_write_reg <= 1'b0;
            avs_addr_reg  <= '0;
            avs_wdata_reg <= '0;
            rd_tid_reg    <= '0;
            rd_data_reg   <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_tid_reg   <= '0;
            rsp_data_reg  <= '0;
            timeout_reg   <= 1'b0;
            drop_cnt_reg  <= '0;
            page_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            avs_read_reg  <= avs_read_next;
            avs_write_reg <= avs_write_next;
            avs_addr_reg  <= avs_addr_next;
            avs_wdata_reg <= avs_wdata_next;
            rd_tid_reg    <= rd_tid_next;
            rd_data_reg   <= rd_data_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_tid_reg   <= rsp_tid_next;
            rsp_data_reg  <= rsp_data_next;
            timeout_reg   <= timeout_next;
            drop_cnt_reg  <= drop_cnt_next;
            page_reg      <= page_next;
        end
    end

    assign bus.rsp_valid      = rsp_valid_reg;
    assign bus.rsp_tid        = rsp_tid_reg;
    assign bus.rsp_data       = rsp_data_reg;
    assign bus.avs_address    = avs_addr_reg;
    assign bus.avs_read       = avs_read_reg;
    assign bus.avs_write      = avs_write_reg;
    assign bus.avs_writedata  = avs_wdata_reg;
    assign bus.avs_byteenable = (avs_read_reg || avs_write_reg) ? 8'hFF : 8'h00;
endmodule

// File: tb/tb_mmio_csr_avmm_bridge.sv
// Bench for mmio_csr_avmm_bridge: directed scenarios plus random CSR/window traffic,
// with a tid-keyed response scoreboard and an AVMM slave model that checks each accepted access.
module tb_mmio_csr_avmm_bridge;
    localparam logic [63:0] ID_H  = 64'hC0DE_0001_2345_6789;
    localparam logic [63:0] ID_L  = 64'h8765_4321_FACE_B00C;
    localparam int          NS    = 4;
    localparam int          AW    = 32;
    localparam int          TO    = 512;
    localparam logic [15:0] BASE  = 16'h1000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk_400 = 1'b0;
    logic soft_reset_n = 1'b0;
    always #5 clk_400 = ~clk_400;

    mmio_csr_avmm_bridge_if #(.AVMM_ADDR_W(AW)) bus ();

    mmio_csr_avmm_bridge #(
        .AFU_ID_H(ID_H), .AFU_ID_L(ID_L), .NUM_SCRATCH(NS),
        .AVMM_BASE(BASE), .AVMM_ADDR_W(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clk_400(clk_400),
        .SoftReset_n(soft_reset_n),
        .bus(bus)
    );

    typedef struct { logic [8:0] tid; logic [63:0] data; int due; } rsp_t;
    typedef struct { logic wr; logic [31:0] addr; logic [63:0] wdata; } av_t;

    rsp_t rsp_q[$];
    av_t  av_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    // Reference model state
    logic [63:0] m_scratch [NS];
    logic [17:0] m_page;
    logic        m_timeout;
    logic        m_busy;
    int          m_drop;
    logic [8:0]  tid_ctr = 9'h100;

    // AVMM slave behaviour knobs
    int          cfg_ws = 0;
    int          cfg_lat = 0;
    logic [63:0] cfg_rdata = '0;
    int          accepts = 0;

    always @(posedge clk_400) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_local(input logic [15:0] a);
        if (a == 16'h0000) return 64'h1000_0100_0000_0000;
        if (a == 16'h0002) return ID_L;
        if (a == 16'h0004) return ID_H;
        if (a == 16'h0010) return {48'h0, 8'((m_drop > 255) ? 255 : m_drop), 6'h0, m_timeout, m_busy};
        if (a == 16'h0012) return 64'(m_page);
        for (int i = 0; i < NS; i++)
            if (a == 16'(32'h20 + 2 * i)) return m_scratch[i];
        return 64'h0;
    endfunction

    function automatic logic [31:0] model_byte_addr(input logic [15:0] a);
        return (32'(m_page) * 32'd16384) + (32'(a & 16'h0FFF) * 32'd4);
    endfunction

    function automatic logic [8:0] next_tid();
        tid_ctr = tid_ctr + 9'd1;
        return tid_ctr;
    endfunction

    // Drive one MMIO beat; called at a negedge, returns at the next negedge
    task automatic drive(input logic wr, input logic [15:0] a, input logic [8:0] tid, input logic [63:0] d);
        bus.mmio_wr_valid = wr;
        bus.mmio_rd_valid = !wr;
        bus.mmio_addr     = a;
        bus.mmio_tid      = tid;
        bus.mmio_wrdata   = d;
        @(negedge clk_400);
        bus.mmio_wr_valid = 1'b0;
        bus.mmio_rd_valid = 1'b0;
    endtask

    task automatic local_rd(input logic [15:0] a, input logic [8:0] tid);
        rsp_q.push_back('{tid, model_local(a), cyc + 1});
        drive(1'b0, a, tid, 64'h0);
    endtask

    task automatic local_wr(input logic [15:0] a, input logic [63:0] d);
        for (int i = 0; i < NS; i++)
            if (a == 16'(32'h20 + 2 * i)) m_scratch[i] = d;
        if (a == 16'h0012) m_page = d[17:0];
        if (a == 16'h0010 && d[1]) m_timeout = 1'b0;
        drive(1'b1, a, 9'h0, d);
    endtask

    task automatic wait_drain(input int limit, input string name);
        int n;
        n = 0;
        while (rsp_q.size() != 0 && n < limit) begin
            @(negedge clk_400);
            n++;
        end
        chk(name, 64'(rsp_q.size()), 64'h0);
        rsp_q.delete();
    endtask

    task automatic win_wr(input logic [15:0] a, input logic [63:0] d, input int ws);
        int start;
        int n;
        cfg_ws = ws;
        av_q.push_back('{1'b1, model_byte_addr(a), d});
        m_busy = 1'b1;
        start = accepts;
        drive(1'b1, a, 9'h0, d);
        n = 0;
        while (accepts == start && n < 100) begin
            @(negedge clk_400);
            n++;
        end
        chk("win_wr_accepted", 64'(accepts - start), 64'h1);
        @(negedge clk_400);
        m_busy = 1'b0;
    endtask

    // lat < 0: slave accepts but never returns data, so the bridge must time out
    task automatic win_rd(input logic [15:0] a, input logic [8:0] tid, input int ws, input int lat,
                          input logic [63:0] d, input logic wait_done);
        cfg_ws = ws;
        cfg_lat = lat;
        cfg_rdata = d;
        av_q.push_back('{1'b0, model_byte_addr(a), 64'h0});
        rsp_q.push_back('{tid, (lat < 0) ? ONES : d, -1});
        m_busy = 1'b1;
        drive(1'b0, a, tid, 64'h0);
        if (wait_done) begin
            wait_drain(TO + 200, "win_rd_response");
            m_busy = 1'b0;
            if (lat < 0) m_timeout = 1'b1;
        end
    endtask

    // Response monitor: matches each response to its expectation by tid
    initial begin
        int idx;
        forever begin
            @(negedge clk_400);
            if (soft_reset_n && bus.rsp_valid) begin
                idx = -1;
                foreach (rsp_q[i])
                    if (idx < 0 && rsp_q[i].tid == bus.rsp_tid) idx = i;
                if (idx < 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got tid %h data %h, expected no response", bus.rsp_tid, bus.rsp_data);
                end else begin
                    chk("rsp_data", bus.rsp_data, rsp_q[idx].data);
                    if (rsp_q[idx].due >= 0) chk("rsp_latency", 64'(cyc), 64'(rsp_q[idx].due));
                    rsp_q.delete(idx);
                end
            end
        end
    end

    // AVMM slave model: stalls cfg_ws cycles, then accepts and checks the access
    initial begin
        bit sl_active;
        int sl_wait;
        int sl_cycles;
        int rdv_cnt;
        av_t av;
        sl_active = 0;
        sl_wait = 0;
        sl_cycles = 0;
        rdv_cnt = 0;
        bus.avs_waitrequest = 1'b0;
        bus.avs_readdatavalid = 1'b0;
        bus.avs_readdata = '0;
        forever begin
            @(negedge clk_400);
            bus.avs_readdatavalid = 1'b0;
            if (rdv_cnt > 0) begin
                rdv_cnt--;
                if (rdv_cnt == 0) begin
                    bus.avs_readdatavalid = 1'b1;
                    bus.avs_readdata = cfg_rdata;
                end
            end
            if (soft_reset_n && (bus.avs_read || bus.avs_write)) begin
                if (!sl_active) begin
                    sl_active = 1;
                    sl_wait = cfg_ws;
                    sl_cycles = 0;
                end
                sl_cycles++;
                if (sl_wait > 0) begin
                    bus.avs_waitrequest = 1'b1;
                    sl_wait--;
                end else begin
                    bus.avs_waitrequest = 1'b0;
                    accepts++;
                    chk("avs_byteenable", 64'(bus.avs_byteenable), 64'hFF);
                    chk("avs_strobe_cycles", 64'(sl_cycles), 64'(cfg_ws + 1));
                    if (av_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL avs_unexpected: got addr %h wr %b, expected no access", bus.avs_address, bus.avs_write);
                    end else begin
                        av = av_q.pop_front();
                        chk("avs_write", 64'(bus.avs_write), 64'(av.wr));
                        chk("avs_address", 64'(bus.avs_address), 64'(av.addr));
                        if (av.wr) chk("avs_writedata", bus.avs_writedata, av.wdata);
                    end
                    if (bus.avs_read) begin
                        if (cfg_lat == 0) begin
                            bus.avs_readdatavalid = 1'b1;
                            bus.avs_readdata = cfg_rdata;
                        end else if (cfg_lat > 0) begin
                            rdv_cnt = cfg_lat;
                        end
                    end
                end
            end else begin
                sl_active = 0;
                bus.avs_waitrequest = 1'b0;
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk_400);
        $display("FAIL watchdog: got no end of test, expected finish within 90000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_scratch[i] = '0;
        m_page = '0;
        m_timeout = 1'b0;
        m_busy = 1'b0;
        m_drop = 0;
    endtask

    // Main stimulus
    initial begin
        logic [15:0] a;
        logic [63:0] d;
        int op;
        bus.mmio_wr_valid = 1'b0;
        bus.mmio_rd_valid = 1'b0;
        bus.mmio_addr = '0;
        bus.mmio_tid = '0;
        bus.mmio_wrdata = '0;
        model_reset();

        repeat (3) @(negedge clk_400);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("reset_avs_read", 64'(bus.avs_read), 64'h0);
        chk("reset_avs_write", 64'(bus.avs_write), 64'h0);
        chk("reset_avs_byteenable", 64'(bus.avs_byteenable), 64'h0);
        chk("reset_avs_address", 64'(bus.avs_address), 64'h0);
        chk("reset_rsp_data", bus.rsp_data, 64'h0);
        soft_reset_n = 1'b1;
        @(negedge clk_400);

        // Header reads
        local_rd(16'h0000, 9'h05);
        local_rd(16'h0002, 9'h06);
        local_rd(16'h0004, 9'h07);
        local_rd(16'h0010, next_tid());
        local_rd(16'h0008, next_tid());
        wait_drain(20, "header_drain");

        // Scratch write/readback
        local_wr(16'(32'h20 + 2 * (NS - 1)), 64'hDEAD_BEEF_0123_4567);
        local_rd(16'(32'h20 + 2 * (NS - 1)), next_tid());
        local_rd(16'h0020, next_tid());
        wait_drain(20, "scratch_drain");

        // Paged window write with 3 stall cycles, then window read with 5-cycle data latency
        local_wr(16'h0012, 64'h1);
        win_wr(16'h1006, 64'hA5, 3);
        win_rd(16'h1000, 9'h1A, 0, 5, 64'h1234, 1'b1);

        // Read timeout, sticky bit, W1C clear
        win_rd(16'h1100, next_tid(), 0, -1, 64'h0, 1'b1);
        local_rd(16'h0010, next_tid());
        local_wr(16'h0010, 64'h2);
        local_rd(16'h0010, next_tid());
        wait_drain(20, "timeout_status_drain");

        // Window traffic while busy is dropped; local access still served
        win_rd(16'h1040, next_tid(), 30, 2, 64'hBEEF_0000_CAFE_0001, 1'b0);
        rsp_q.push_back('{next_tid(), ONES, cyc + 1});
        drive(1'b0, 16'h1080, tid_ctr, 64'h0);
        m_drop++;
        drive(1'b1, 16'h10C0, 9'h0, 64'h5555);
        m_drop++;
        local_rd(16'h0010, next_tid());
        local_rd(16'h0020, next_tid());
        wait_drain(200, "busy_drain");
        m_busy = 1'b0;
        local_rd(16'h0010, next_tid());
        wait_drain(20, "drop_status_drain");

        // Random mix
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 7);
            d = {$urandom, $urandom};
            case (op)
                0: local_wr(16'(32'h20 + 2 * $urandom_range(0, NS - 1)), d);
                1: local_rd(16'(32'h20 + 2 * $urandom_range(0, NS - 1)), next_tid());
                2: local_wr(16'h0012, d);
                3: local_rd(16'h0012, next_tid());
                4: local_rd(16'h0010, next_tid());
                5: begin
                    a = 16'(2 * $urandom_range(0, 40));
                    local_rd(a, next_tid());
                end
                6: win_wr(16'(32'h1000 + 2 * $urandom_range(0, 2047)), d, $urandom_range(0, 3));
                default: win_rd(16'(32'h1000 + 2 * $urandom_range(0, 2047)), next_tid(),
                                $urandom_range(0, 3), $urandom_range(0, 5), d, 1'b1);
            endcase
            wait_drain(20, "random_drain");
        end

        // Writes to read-only header are ignored
        local_wr(16'h0000, 64'h0);
        local_wr(16'h0004, 64'h0);
        local_rd(16'h0000, next_tid());
        local_rd(16'h0004, next_tid());
        wait_drain(20, "ro_drain");

        // Reset in the middle of a stalled window read
        cfg_ws = 50;
        cfg_lat = -1;
        drive(1'b0, 16'h1010, next_tid(), 64'h0);
        repeat (3) @(negedge clk_400);
        chk("pre_reset_avs_read", 64'(bus.avs_read), 64'h1);
        soft_reset_n = 1'b0;
        #1;
        chk("mid_reset_avs_read", 64'(bus.avs_read), 64'h0);
        chk("mid_reset_byteenable", 64'(bus.avs_byteenable), 64'h0);
        model_reset();
        @(negedge clk_400);
        @(negedge clk_400);
        soft_reset_n = 1'b1;
        @(negedge clk_400);
        local_rd(16'(32'h20 + 2 * (NS - 1)), next_tid());
        local_rd(16'h0010, next_tid());
        local_rd(16'h0012, next_tid());
        wait_drain(20, "post_reset_drain");
        repeat (60) @(negedge clk_400);
        chk("leftover_avmm_expectations", 64'(av_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
